// File: rtl/cios_pkg.sv
// Shared state encoding and scratchpad sizing helpers for the CIOS Montgomery controller.
package cios_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_S           = 8;
    localparam int DEF_DRAIN       = 4;
    localparam int DEF_ROW_TIMEOUT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ROW_START,
        ST_ROW_WAIT,
        ST_DRAIN,
        ST_SUB,
        ST_OUT
    } state_t;

    // The scratchpad carries two extra words above the S operand words.
    function automatic int t_depth(input int s);
        return s + 2;
    endfunction

    function automatic int t_addr_w(input int s);
        return $clog2(s + 2);
    endfunction

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cios_condsub.sv
// Word-serial T - P with borrow chain, plus the final select between T and T - P.
module cios_condsub
    import cios_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int S     = DEF_S,
    parameter int IW    = idx_w(DEF_S)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               step,
    input  logic [IW-1:0]      j,
    input  logic [WIDTH-1:0]   t_word,
    input  logic [WIDTH-1:0]   p_word,
    input  logic [WIDTH-1:0]   t_top,
    input  logic [S*WIDTH-1:0] t_low,
    output logic [S*WIDTH-1:0] result
);

    logic [S*WIDTH-1:0] d_reg;
    logic [S*WIDTH-1:0] d_full;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic               bout;
    logic               fb;
    logic               take_d;

    // result is only meaningful while the last word is being stepped; it folds in
    // the word currently in flight so the caller can capture it on that same edge.
    always_comb begin
        diff   = {1'b0, t_word} - {1'b0, p_word} - {{WIDTH{1'b0}}, borrow};
        bout   = diff[WIDTH];
        fb     = bout | (t_top < {{(WIDTH-1){1'b0}}, bout});
        take_d = (t_top != '0) || !fb;
        d_full = d_reg;
        d_full[j*WIDTH +: WIDTH] = diff[WIDTH-1:0];
        result = take_d ? d_full : t_low;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg  <= '0;
            borrow <= 1'b0;
        end else if (init) begin
            d_reg  <= '0;
            borrow <= 1'b0;
        end else if (step) begin
            d_reg[j*WIDTH +: WIDTH] <= diff[WIDTH-1:0];
            borrow                  <= bout;
        end
    end

endmodule

// File: rtl/cios_mont_ctrl.sv
// Sequencer for one CIOS row unit: S row passes over an S+2 word scratchpad, then conditional subtract.
// Optional per-row watchdog enabled by defining CIOS_CTRL_TIMEOUT_EN.
module cios_mont_ctrl
    import cios_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int S           = DEF_S,
    parameter int DRAIN       = DEF_DRAIN,
    parameter int ROW_TIMEOUT = DEF_ROW_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    input  logic [S*WIDTH-1:0]          a_in,
    input  logic [S*WIDTH-1:0]          b_in,
    input  logic [S*WIDTH-1:0]          p_in,
    input  logic [WIDTH-1:0]            p_prime_in,
    output logic [S*WIDTH-1:0]          res,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        row_start,
    output logic                        row_flush,
    output logic [WIDTH-1:0]            row_a,
    output logic [S*WIDTH-1:0]          row_b,
    output logic [S*WIDTH-1:0]          row_p,
    output logic [WIDTH-1:0]            row_p_prime,
    output logic [t_depth(S)*WIDTH-1:0] row_T,
    input  logic                        row_we,
    input  logic [t_addr_w(S)-1:0]      row_waddr,
    input  logic [WIDTH-1:0]            row_wdata,
    input  logic                        row_done,
    output logic                        err
);

    localparam int T_DEPTH = t_depth(S);
    localparam int AW      = t_addr_w(S);
    localparam int IW      = idx_w(S);
    localparam int DW      = idx_w(DRAIN + 1);

    state_t             state;
    logic [IW-1:0]      i_idx;
    logic [IW-1:0]      j_idx;
    logic [DW-1:0]      dcnt;
    logic [S*WIDTH-1:0] a_reg;
    logic [S*WIDTH-1:0] sub_result;
    logic               wr_window;
    logic               start_acc;

`ifdef CIOS_CTRL_TIMEOUT_EN
    localparam int TW = idx_w(ROW_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^ROW_TIMEOUT;
    assign err        = 1'b0;
`endif

    assign row_a     = a_reg[i_idx*WIDTH +: WIDTH];
    assign wr_window = (state == ST_ROW_WAIT) || (state == ST_DRAIN);
    assign start_acc = (state == ST_IDLE) && start;

    cios_condsub #(
        .WIDTH (WIDTH),
        .S     (S),
        .IW    (IW)
    ) u_condsub (
        .clk    (clk),
        .rst    (rst),
        .init   (start_acc),
        .step   (state == ST_SUB),
        .j      (j_idx),
        .t_word (row_T[j_idx*WIDTH +: WIDTH]),
        .p_word (row_p[j_idx*WIDTH +: WIDTH]),
        .t_top  (row_T[S*WIDTH +: WIDTH]),
        .t_low  (row_T[S*WIDTH-1:0]),
        .result (sub_result)
    );

    // Row writes land only while a row is running or draining; addresses past
    // the scratchpad match no word and are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            i_idx       <= '0;
            j_idx       <= '0;
            dcnt        <= '0;
            a_reg       <= '0;
            row_b       <= '0;
            row_p       <= '0;
            row_p_prime <= '0;
            row_T       <= '0;
            res         <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            row_start   <= 1'b0;
            row_flush   <= 1'b0;
`ifdef CIOS_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            err         <= 1'b0;
`endif
        end else begin
            row_start <= 1'b0;
            row_flush <= 1'b0;
            if (wr_window && row_we) begin
                for (int k = 0; k < T_DEPTH; k++) begin
                    if (row_waddr == AW'(k)) begin
                        row_T[k*WIDTH +: WIDTH] <= row_wdata;
                    end
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg       <= a_in;
                        row_b       <= b_in;
                        row_p       <= p_in;
                        row_p_prime <= p_prime_in;
                        row_T       <= '0;
                        i_idx       <= '0;
                        busy        <= 1'b1;
                        row_flush   <= 1'b1;
                        state       <= ST_FLUSH;
`ifdef CIOS_CTRL_TIMEOUT_EN
                        err         <= 1'b0;
`endif
                    end
                end
                ST_FLUSH: begin
                    row_start <= 1'b1;
                    state     <= ST_ROW_START;
                end
                ST_ROW_START: begin
`ifdef CIOS_CTRL_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= ST_ROW_WAIT;
                end
                ST_ROW_WAIT: begin
                    if (row_done) begin
                        dcnt  <= DW'(DRAIN);
                        state <= ST_DRAIN;
                    end
`ifdef CIOS_CTRL_TIMEOUT_EN
                    else if (tmo_cnt == TW'(ROW_TIMEOUT)) begin
                        row_flush <= 1'b1;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (dcnt == '0) begin
                        if (i_idx == IW'(S - 1)) begin
                            j_idx <= '0;
                            state <= ST_SUB;
                        end else begin
                            i_idx     <= i_idx + 1'b1;
                            row_flush <= 1'b1;
                            state     <= ST_FLUSH;
                        end
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                ST_SUB: begin
                    if (j_idx == IW'(S - 1)) begin
                        res       <= sub_result;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
